// File: rtl/led_scan_reader_pkg.sv
// Shared types and constants for the LED frame-buffer scan engine.
package led_scan_reader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREFETCH,
      SHIFT,
      LATCH,
      DISPLAY
   } state_t;

   localparam int PREFETCH_CYCLES = 2;
   localparam int LATCH_CYCLES    = 2;

   function automatic int cols_of(input int col_bits);
      return 2 ** col_bits;
   endfunction

   function automatic int rows_of(input int row_bits);
      return 2 ** row_bits;
   endfunction

   function automatic int oe_cnt_width(input int oe_cycles);
      return $clog2(oe_cycles + 1);
   endfunction

endpackage

// File: rtl/led_scan_reader.sv
// Scans the frame buffer row by row, shifts rows to the panel,
// latches them and lights each row for a fixed on-time.
module led_scan_reader
   import led_scan_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 13,
   parameter int COL_BITS   = 8,
   parameter int ROW_BITS   = ADDR_WIDTH - COL_BITS,
   parameter int OE_CYCLES  = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] led_data,
   output logic                  sclk,
   output logic                  lat,
   output logic                  oe_n,
   output logic [ROW_BITS-1:0]   row_addr,
   output logic                  frame_sync,
   output logic                  busy
);

   localparam int CW = oe_cnt_width(OE_CYCLES);
   localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(cols_of(COL_BITS) - 1);
   localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(rows_of(ROW_BITS) - 1);
   localparam logic [CW-1:0] PF_LAST = CW'(PREFETCH_CYCLES - 1);
   localparam logic [CW-1:0] LT_LAST = CW'(LATCH_CYCLES - 1);
   localparam logic [CW-1:0] OE_LAST = CW'(OE_CYCLES - 1);

   state_t                state_q, state_d;
   logic [COL_BITS-1:0]   col_q, col_d;
   logic [ROW_BITS-1:0]   row_q, row_d;
   logic                  phase_q, phase_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [DATA_WIDTH-1:0] led_data_q, led_data_d;
   logic                  sclk_q, sclk_d;
   logic                  lat_q, lat_d;
   logic                  oe_n_q, oe_n_d;
   logic [ROW_BITS-1:0]   row_addr_q, row_addr_d;
   logic                  frame_sync_q, frame_sync_d;

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      phase_d      = phase_q;
      cnt_d        = cnt_q;
      rd_addr_d    = rd_addr_q;
      led_data_d   = led_data_q;
      sclk_d       = sclk_q;
      lat_d        = 1'b0;
      oe_n_d       = oe_n_q;
      row_addr_d   = row_addr_q;
      frame_sync_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            sclk_d = 1'b0;
            oe_n_d = 1'b1;
            if (en) begin
               row_d        = '0;
               col_d        = '0;
               cnt_d        = '0;
               rd_addr_d    = '0;
               frame_sync_d = 1'b1;
               state_d      = PREFETCH;
            end
         end
         PREFETCH: begin
            if (cnt_q == PF_LAST) begin
               cnt_d   = '0;
               col_d   = '0;
               phase_d = 1'b0;
               state_d = SHIFT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SHIFT: begin
            if (!phase_q) begin
               led_data_d = rd_data;
               sclk_d     = 1'b0;
               phase_d    = 1'b1;
               if (col_q != COL_LAST)
                  rd_addr_d = {row_q, col_q + 1'b1};
            end else begin
               sclk_d  = 1'b1;
               phase_d = 1'b0;
               col_d   = col_q + 1'b1;
               // Latch strobe and row select move together, ahead of oe_n.
               if (col_q == COL_LAST) begin
                  cnt_d      = '0;
                  lat_d      = 1'b1;
                  row_addr_d = row_q;
                  state_d    = LATCH;
               end
            end
         end
         LATCH: begin
            oe_n_d = 1'b1;
            if (cnt_q == LT_LAST) begin
               cnt_d   = '0;
               oe_n_d  = 1'b0;
               state_d = DISPLAY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DISPLAY: begin
            if (cnt_q == OE_LAST) begin
               cnt_d  = '0;
               oe_n_d = 1'b1;
               row_d  = row_q + 1'b1;
               if (en) begin
                  rd_addr_d    = {row_q + 1'b1, {COL_BITS{1'b0}}};
                  frame_sync_d = (row_q == ROW_LAST);
                  state_d      = PREFETCH;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            oe_n_d  = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         phase_q      <= 1'b0;
         cnt_q        <= '0;
         rd_addr_q    <= '0;
         led_data_q   <= '0;
         sclk_q       <= 1'b0;
         lat_q        <= 1'b0;
         oe_n_q       <= 1'b1;
         row_addr_q   <= '0;
         frame_sync_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         phase_q      <= phase_d;
         cnt_q        <= cnt_d;
         rd_addr_q    <= rd_addr_d;
         led_data_q   <= led_data_d;
         sclk_q       <= sclk_d;
         lat_q        <= lat_d;
         oe_n_q       <= oe_n_d;
         row_addr_q   <= row_addr_d;
         frame_sync_q <= frame_sync_d;
      end
   end

   assign rd_addr    = rd_addr_q;
   assign led_data   = led_data_q;
   assign sclk       = sclk_q;
   assign lat        = lat_q;
   assign oe_n       = oe_n_q;
   assign row_addr   = row_addr_q;
   assign frame_sync = frame_sync_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_led_scan_reader.sv
// Bench for led_scan_reader: 1-latency RAM model, event-level
// reference checks on shifted data, latch, on-time and frame timing.
module tb_led_scan_reader;

   localparam int DW   = 16;
   localparam int AW   = 3;
   localparam int CB   = 2;
   localparam int RB   = 1;
   localparam int OE   = 8;
   localparam int COLS = 4;
   localparam int ROWS = 2;
   localparam int ROWP = 2 + 2 * COLS + 2 + OE;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] led_data;
   logic          sclk;
   logic          lat;
   logic          oe_n;
   logic [RB-1:0] row_addr;
   logic          frame_sync;
   logic          busy;

   logic [DW-1:0] mem [8];

   int n_vec = 0;
   int n_bad = 0;

   led_scan_reader #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .COL_BITS  (CB),
      .ROW_BITS  (RB),
      .OE_CYCLES (OE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .led_data  (led_data),
      .sclk      (sclk),
      .lat       (lat),
      .oe_n      (oe_n),
      .row_addr  (row_addr),
      .frame_sync(frame_sync),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_data <= mem[rd_addr];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Event-level reference: rows in order, COLS words per row
   int   cyc = 0;
   int   exp_row, col_idx, oe_len, last_lat, last_fs;
   int   fs_cnt = 0;
   int   lat_cnt = 0;
   bit   have_lat, have_fs;
   logic p_sclk, p_oe;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         exp_row  = 0;
         col_idx  = 0;
         oe_len   = 0;
         have_lat = 0;
         have_fs  = 0;
         p_sclk   = 1'b0;
         p_oe     = 1'b1;
      end else begin
         if (sclk && !p_sclk) begin
            chk("led", 32'(led_data),
                32'(mem[{exp_row[0], col_idx[1:0]}]));
            col_idx++;
         end
         if (lat) begin
            lat_cnt++;
            chk("lat_row", 32'(row_addr), exp_row % ROWS);
            chk("lat_cols", col_idx, COLS);
            col_idx = 0;
            oe_len  = 0;
            if (have_lat) chk("row_period", cyc - last_lat, ROWP);
            last_lat = cyc;
            have_lat = 1;
         end
         if (!oe_n) begin
            oe_len++;
            chk("ovl_lat", 32'(lat), 0);
            chk("ovl_row", 32'(row_addr), exp_row % ROWS);
         end
         if (oe_n && !p_oe) begin
            chk("oe_len", oe_len, OE);
            exp_row++;
         end
         if (frame_sync) begin
            fs_cnt++;
            chk("fs_addr", 32'(rd_addr), 0);
            chk("fs_col", col_idx, 0);
            if (have_fs) chk("fs_period", cyc - last_fs, 2 * ROWP);
            last_fs = cyc;
            have_fs = 1;
         end
         if (!busy) begin
            exp_row  = 0;
            col_idx  = 0;
            have_lat = 0;
            have_fs  = 0;
         end
         p_sclk = sclk;
         p_oe   = oe_n;
      end
   end

   task automatic fill_ramp();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            mem[r*COLS+c] = DW'(16'h0100 * r + c);
   endtask

   task automatic chk_rst();
      chk("rst_addr", 32'(rd_addr), 0);
      chk("rst_led", 32'(led_data), 0);
      chk("rst_sclk", 32'(sclk), 0);
      chk("rst_lat", 32'(lat), 0);
      chk("rst_oe_n", 32'(oe_n), 1);
      chk("rst_row", 32'(row_addr), 0);
      chk("rst_fs", 32'(frame_sync), 0);
      chk("rst_busy", 32'(busy), 0);
   endtask

   task automatic wait_idle(input string tag, input int lim);
      int k = 0;
      while (busy && k < lim) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(busy), 0);
   endtask

   initial begin
      int fs0, lat0, n;
      rst_n = 1'b0;
      en    = 1'b0;
      fill_ramp();
      repeat (3) @(negedge clk);
      chk_rst();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic frames, startup latency and frame count
      fs0 = fs_cnt;
      lat0 = lat_cnt;
      en = 1'b1;
      @(posedge clk); #1;
      chk("fs_first", 32'(frame_sync), 1);
      chk("busy_on", 32'(busy), 1);
      repeat (3) @(posedge clk);
      #1 chk("sclk_pre", 32'(sclk), 0);
      @(posedge clk); #1;
      chk("sclk_1st", 32'(sclk), 1);
      chk("led_1st", 32'(led_data), 32'h0000);
      repeat (110) @(negedge clk);
      en = 1'b0;
      wait_idle("idle_basic", 60);
      chk("fs_count", fs_cnt - fs0, 3);
      chk("lat_count", lat_cnt - lat0, 6);

      // Early stop during SHIFT of row 0
      repeat (3) @(negedge clk);
      lat0 = lat_cnt;
      n = 0;
      en = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
         if (n == 6) en = 1'b0;
      end
      chk("busy_len", n, ROWP);
      chk("stop_lat", lat_cnt - lat0, 1);
      chk("stop_oe_n", 32'(oe_n), 1);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         chk("idle_addr", 32'(rd_addr), 3);
      end
      chk("idle_sclk", 32'(sclk), 0);
      chk("idle_busy", 32'(busy), 0);

      // Random contents and random enable windows
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 8; i++) mem[i] = DW'($urandom);
         en = 1'b1;
         repeat ($urandom_range(5, 120)) @(negedge clk);
         en = 1'b0;
         wait_idle("idle_rand", 80);
         repeat ($urandom_range(1, 15)) @(negedge clk);
      end

      // Reset in the middle of DISPLAY
      fill_ramp();
      en = 1'b1;
      n = 0;
      while (oe_n && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach_disp", 32'(oe_n), 0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_rst();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rs_fs", 32'(frame_sync), 1);
      chk("rs_addr", 32'(rd_addr), 0);
      repeat (3) @(posedge clk);
      @(posedge clk); #1;
      chk("rs_sclk", 32'(sclk), 1);
      chk("rs_led", 32'(led_data), 32'h0000);
      repeat (2 * 2 * ROWP) @(negedge clk);
      en = 1'b0;
      wait_idle("idle_end", 60);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule

// File: doc/led_scan_reader.md
# led_scan_reader

Read-side scan engine for the LED frame buffer. It walks the buffer row by row through the buffer's synchronous read port, which has one-cycle read latency. It shifts each row out to the panel drivers as 16 parallel data lines with a generated shift clock, then latches the row, drives its row address and enables the outputs for a programmable on-time. It is the consumer paired with the frame-buffer write path and reports frame boundaries so the writer can swap or refresh content.

## Interface
Parameters:
- DATA_WIDTH, 16, frame-buffer word width; one bit per panel data line
- ADDR_WIDTH, 13, frame-buffer address width; address = {row, col}
- COL_BITS, 8, column index width; COLS = 2**COL_BITS
- ROW_BITS, ADDR_WIDTH-COL_BITS, row index width; ROWS = 2**ROW_BITS
- OE_CYCLES, 64, clk cycles oe_n is held low per row (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, also the frame-buffer read clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable, level-sensitive
- rd_addr  out  ADDR_WIDTH  frame-buffer read address, registered
- rd_data  in  DATA_WIDTH  frame-buffer read data, valid one clk after rd_addr is sampled
- led_data  out  DATA_WIDTH  panel serial data lines, registered
- sclk  out  1  panel shift clock; panel samples on rising edge
- lat  out  1  panel latch strobe, active-high
- oe_n  out  1  panel output enable, active-low
- row_addr  out  ROW_BITS  panel row select, registered
- frame_sync  out  1  one-cycle pulse at frame start
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, PREFETCH, SHIFT, LATCH, DISPLAY.
- IDLE: oe_n=1, sclk=0, lat=0. When en=1, load row counter with 0, set rd_addr={0,0}, pulse frame_sync and go to PREFETCH.
- PREFETCH: 2 cycles. rd_addr holds {row,0}. Then go to SHIFT with col=0, phase=0.
- SHIFT, phase 0: led_data<=rd_data (word {row,col}), sclk<=0, rd_addr<={row,col+1} (not updated when col=COLS-1).
- SHIFT, phase 1: sclk<=1.
- SHIFT exit: after phase 1 of col=COLS-1, go to LATCH. col wraps naturally.
- LATCH: 2 cycles. In cycle 1, lat=1 and row_addr<=row. In cycle 2, lat=0. oe_n=1 throughout.
- DISPLAY: oe_n=0 for exactly OE_CYCLES cycles, then oe_n=1 and row<=row+1 (mod ROWS).
- After DISPLAY, if en=0, go to IDLE. Otherwise set rd_addr={row+1,0} and go to PREFETCH.
- Row wrap: when row+1 wraps from ROWS-1 to 0, frame_sync pulses on the cycle PREFETCH is entered.
- en deasserted mid-row: the current row completes through DISPLAY, then the block goes to IDLE. A row is never truncated.
- oe_n is never low while lat=1 or while row_addr changes.

## Timing
- Reset value of every output is 0, except oe_n, which resets to 1.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously). State returns to IDLE.
- rd_data is consumed exactly 2 clk edges after the rd_addr change it depends on.
- led_data is stable ≥1 cycle before each sclk rise and ≥1 cycle after it.
- Row period = 2 + 2·COLS + 2 + OE_CYCLES cycles.
- Frame period = ROWS × row period.
- First sclk rise occurs 4 cycles after en is sampled high in IDLE.

## Structure
- Shared package holds:
  - state enum (IDLE, PREFETCH, SHIFT, LATCH, DISPLAY)
  - derived constants COLS, ROWS, PREFETCH_CYCLES=2, LATCH_CYCLES=2
  - OE counter width $clog2(OE_CYCLES+1)
- Single module, no sub-module. Counters (col, row, phase, cycle) live inline with the FSM.

## Test plan
Directed scenarios use COL_BITS=2, ROW_BITS=1, OE_CYCLES=8, with the bench modelling a 1-latency RAM.
- Basic frame: RAM word {r,c} = 16'h0100·r+c; en=1 → per row, led_data at the 4 sclk rises is r00,r01,r02,r03 (hex). Then one lat pulse with row_addr=r. Row period is 20 cycles and oe_n is low for exactly 8.
- Frame sync: en held for 3 frames → frame_sync pulses every 40 cycles, first on the cycle after en is sampled.
- Early stop: en dropped during SHIFT of row 0 → row 0 completes LATCH and 8-cycle DISPLAY, then IDLE. busy=0, oe_n=1, and no further rd_addr changes.
- Reset mid-DISPLAY: rst_n low → oe_n=1 and all other outputs 0 in the same cycle. After release with en=1, scanning restarts at row 0, col 0.
- Overlap guard: across any 2 frames, a monitor asserts no cycle has oe_n=0 together with lat=1, and row_addr never changes while oe_n=0.
